fir_sdiv_32s_8s_32_seq: RTL and testbench
=========================================

Name: fir_sdiv_32s_8s_32_seq

Overview:
- Iterative signed divider: 32-bit signed dividend by 8-bit signed divisor, producing a 32-bit quotient and an 8-bit remainder.
- It is the inverse datapath of the FIR tap multiplier and is used for gain normalisation and coefficient rescaling after accumulation.
- Restoring algorithm, one quotient bit per enabled clock, with a start/ready/done handshake and a global clock-enable.

Parameters:
- din0_WIDTH, 32, dividend width (signed).
- din1_WIDTH, 8, divisor width (signed), 2 ≤ din1_WIDTH ≤ din0_WIDTH.
- dout_WIDTH, 32, quotient width; must equal din0_WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- ce  input  1  clock enable; when low, all state and outputs freeze.
- start  input  1  request; sampled only when ready=1 and ce=1.
- din0  input  din0_WIDTH  signed dividend, captured on accepted start.
- din1  input  din1_WIDTH  signed divisor, captured on accepted start.
- ready  output  1  high in IDLE; block can accept start.
- done  output  1  one-cycle pulse when quot/rem are valid.
- quot  output  dout_WIDTH  signed quotient, registered, held until the next done.
- rem  output  din1_WIDTH  signed remainder, registered, held until the next done.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, ready=1, done=0, quot=0, rem=0, iteration counter=0. Reset mid-operation aborts the operation; no done is produced for the aborted request.
- All sequential updates require ce=1. With ce=0 nothing changes, done included: a done pulse is stretched until the next enabled edge.
- States:
  - IDLE, ready=1. On start&ce: latch |din0| and |din1| as unsigned magnitudes, sign_q=din0[msb]^din1[msb], sign_r=din0[msb], count=din0_WIDTH. Go to CALC, or to DZERO if din1==0. start while not IDLE is ignored.
  - CALC, ready=0. Each enabled edge: partial remainder P (din1_WIDTH+1 bits) = {P, next dividend bit} − divisor. If the result is non-negative, keep it and shift in quotient bit 1; else restore and shift in 0. count−1. Leave for SIGN when count reaches 0, i.e. after din0_WIDTH iterations.
  - SIGN: quot = sign_q ? −Q : Q, truncated to dout_WIDTH. rem = sign_r ? −P : P, truncated to din1_WIDTH. Go to DONE.
  - DZERO: quot = all ones (−1), rem = din0[din1_WIDTH−1:0]. Go to DONE.
  - DONE: done=1 for exactly one enabled cycle, then IDLE (ready=1 again).
- Latency with ce held high: done is high in the cycle din0_WIDTH+2 edges after the start-accept edge (34 for defaults). For divide-by-zero it is 2 edges.
- Arithmetic: C semantics, quotient truncated toward zero, remainder takes the dividend's sign, |rem| < |divisor|.
  - −2^31 / −1: magnitude 2^31 fits unsigned, so quot=0x80000000 (wrap) and rem=0. No trap.
  - −128 divisor: magnitude 128 handled by the (din1_WIDTH+1)-bit partial remainder.
- Back-to-back: start may be high in the same cycle done=1. It is not accepted until ready=1 on the following enabled cycle.

Optional Feature:
- Macro FIR_SDIV_DIVZERO_FLAG_EN.
- When defined: extra output port div_by_zero (1 bit). Reset 0; set to 1 with done for a DZERO result, otherwise 0 with done; held between done pulses.
- When undefined: the port is absent. The DZERO path, its quot/rem values and its 2-cycle latency are unchanged.

Test Plan:
- din0=100, din1=7, start, ce=1 → done at edge 34; quot=14, rem=2; ready back high the next cycle.
- din0=−100, din1=7 → quot=0xFFFFFFF2 (−14), rem=0xFE (−2). din0=100, din1=−7 → quot=−14, rem=2.
- din0=0x80000000, din1=0xFF (−1) → quot=0x80000000, rem=0. din0=1000, din1=0x80 (−128) → quot=−7 (0xFFFFFFF9), rem=104 (0x68).
- din0=1234, din1=0 → done after 2 edges, quot=0xFFFFFFFF, rem=0xD2 (1234 & 0xFF); with the macro defined, div_by_zero=1.
- Start 100/7, drop ce for 5 cycles at iteration 10, then restore → done at edge 39, result 14 r 2. A second start pulsed mid-operation is ignored.
- Start, assert reset=0 at iteration 20 → ready=1, quot=0, rem=0 immediately and no done. A new start of 50/3 then completes with quot=16, rem=2.

Source files
------------

// File: rtl/fir_sdiv_32s_8s_32_seq.sv
// Sequential restoring signed divider, 32s / 8s, one quotient bit per enabled clock.
// Define FIR_SDIV_DIVZERO_FLAG_EN to add the div_by_zero status output.
module fir_sdiv_32s_8s_32_seq #(
    parameter int din0_WIDTH = 32,
    parameter int din1_WIDTH = 8,
    parameter int dout_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  ready,
    output logic                  done,
    output logic [dout_WIDTH-1:0] quot,
`ifdef FIR_SDIV_DIVZERO_FLAG_EN
    output logic [din1_WIDTH-1:0] rem,
    output logic                  div_by_zero
`else
    output logic [din1_WIDTH-1:0] rem
`endif
);

    localparam int W0 = din0_WIDTH;
    localparam int W1 = din1_WIDTH;
    localparam int CW = $clog2(W0 + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CALC  = 3'd1;
    localparam logic [2:0] S_SIGN  = 3'd2;
    localparam logic [2:0] S_DZERO = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W0-1:0]   a_q, a_d;
    logic [W1:0]     p_q, p_d;
    logic [W1-1:0]   dv_q, dv_d;
    logic            sq_q, sq_d;
    logic            sr_q, sr_d;
    logic [dout_WIDTH-1:0] quot_q, quot_d;
    logic [W1-1:0]   rem_q, rem_d;
`ifdef FIR_SDIV_DIVZERO_FLAG_EN
    logic            dz_q, dz_d;
`endif

    logic [W0-1:0]   a_mag;
    logic [W1-1:0]   d_mag;
    logic [W1+1:0]   shifted;
    logic [W1+1:0]   diff;

    assign a_mag = din0[W0-1] ? -din0 : din0;
    assign d_mag = din1[W1-1] ? -din1 : din1;

    // Partial remainder is W1+1 bits so a divisor magnitude of 2^(W1-1) still fits.
    assign shifted = {p_q, a_q[W0-1]};
    assign diff    = shifted - {2'b00, dv_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        p_d     = p_q;
        dv_d    = dv_q;
        sq_d    = sq_q;
        sr_d    = sr_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
`ifdef FIR_SDIV_DIVZERO_FLAG_EN
        dz_d    = dz_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dv_d  = d_mag;
                    sq_d  = din0[W0-1] ^ din1[W1-1];
                    sr_d  = din0[W0-1];
                    p_d   = '0;
                    cnt_d = CW'(W0);
                    if (din1 == '0) begin
                        a_d     = din0;
                        state_d = S_DZERO;
                    end else begin
                        a_d     = a_mag;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                // Dividend bits shift out of a_q's top while quotient bits fill its bottom.
                if (!diff[W1+1]) begin
                    p_d = diff[W1:0];
                    a_d = {a_q[W0-2:0], 1'b1};
                end else begin
                    p_d = shifted[W1:0];
                    a_d = {a_q[W0-2:0], 1'b0};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_SIGN;
                end
            end
            S_SIGN: begin
                quot_d  = sq_q ? -a_q : a_q;
                rem_d   = sr_q ? -p_q[W1-1:0] : p_q[W1-1:0];
`ifdef FIR_SDIV_DIVZERO_FLAG_EN
                dz_d    = 1'b0;
`endif
                state_d = S_DONE;
            end
            S_DZERO: begin
                quot_d  = '1;
                rem_d   = a_q[W1-1:0];
`ifdef FIR_SDIV_DIVZERO_FLAG_EN
                dz_d    = 1'b1;
`endif
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            p_q     <= '0;
            dv_q    <= '0;
            sq_q    <= 1'b0;
            sr_q    <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
`ifdef FIR_SDIV_DIVZERO_FLAG_EN
            dz_q    <= 1'b0;
`endif
        end else if (ce) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            p_q     <= p_d;
            dv_q    <= dv_d;
            sq_q    <= sq_d;
            sr_q    <= sr_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
`ifdef FIR_SDIV_DIVZERO_FLAG_EN
            dz_q    <= dz_d;
`endif
        end
    end

    assign ready = (state_q == S_IDLE);
    assign done  = (state_q == S_DONE);
    assign quot  = quot_q;
    assign rem   = rem_q;
`ifdef FIR_SDIV_DIVZERO_FLAG_EN
    assign div_by_zero = dz_q;
`endif

endmodule

// File: tb/tb_fir_sdiv_32s_8s_32_seq.sv
// Self-checking bench for fir_sdiv_32s_8s_32_seq: vector table,
// random ops against a C-semantics model, ce freeze and reset abort.
module tb_fir_sdiv_32s_8s_32_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        start;
    logic [31:0] din0;
    logic [7:0]  din1;
    logic        ready;
    logic        done;
    logic [31:0] quot;
    logic [7:0]  rem;
`ifdef FIR_SDIV_DIVZERO_FLAG_EN
    logic        div_by_zero;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] q;
        logic [7:0]  r;
        logic        dz;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [7:0]  b;
        logic [31:0] q;
        logic [7:0]  r;
        int          lat;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[9];

    fir_sdiv_32s_8s_32_seq dut (
        .clk        (clk),
        .reset      (reset),
        .ce         (ce),
        .start      (start),
        .din0       (din0),
        .din1       (din1),
        .ready      (ready),
        .done       (done),
        .quot       (quot),
`ifdef FIR_SDIV_DIVZERO_FLAG_EN
        .rem        (rem),
        .div_by_zero(div_by_zero)
`else
        .rem        (rem)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Drive one request and wait for its done pulse. ce_at drops ce for
    // 5 cycles after that many edges and also pulses a stray start.
    task automatic run_op(input logic [31:0] a, input logic [7:0] b,
                          input logic [31:0] eq, input logic [7:0] er,
                          input int lat, input int ce_at, input bit hold);
        int   edges;
        bit   got;
        exp_t e;
        edges = 0;
        got   = 1'b0;
        @(negedge clk);
        chk("ready_pre", {31'b0, ready}, 32'd1);
        din0  = a;
        din1  = b;
        start = 1'b1;
        e.q   = eq;
        e.r   = er;
        e.dz  = (b == 8'h00);
        sb.push_back(e);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            edges++;
            if (done) begin
                got = 1'b1;
                break;
            end
            start = 1'b0;
            if (ce_at >= 0 && edges == 5) begin
                start = 1'b1;
                din0  = 32'd999;
                din1  = 8'd3;
            end
            if (edges == ce_at) begin
                ce = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    edges++;
                end
                ce = 1'b1;
            end
        end
        start = 1'b0;
        if (!got) begin
            chk("done_timeout", 32'd0, 32'd1);
            void'(sb.pop_front());
        end else begin
            chk("latency", edges, lat);
            if (sb.size() == 0) begin
                chk("sb_empty", 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                chk("quot", quot, e.q);
                chk("rem", {24'b0, rem}, {24'b0, e.r});
`ifdef FIR_SDIV_DIVZERO_FLAG_EN
                chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.dz});
`endif
            end
            if (hold) begin
                ce = 1'b0;
                repeat (3) @(negedge clk);
                chk("done_stretch", {31'b0, done}, 32'd1);
                ce = 1'b1;
            end
            @(negedge clk);
            chk("done_pulse", {31'b0, done}, 32'd0);
            chk("ready_post", {31'b0, ready}, 32'd1);
        end
    endtask

    initial begin
        logic signed [31:0] sa;
        logic signed [31:0] sd;
        logic signed [31:0] mq;
        logic signed [31:0] mr;
        logic [31:0]        ra;
        logic [7:0]         rb;
        int                 dcount;

        vecs[0] = '{32'd100,        8'd7,   32'd14,         8'd2,   34};
        vecs[1] = '{-32'sd100,      8'd7,   32'hFFFFFFF2,   8'hFE,  34};
        vecs[2] = '{32'd100,        8'hF9,  32'hFFFFFFF2,   8'h02,  34};
        vecs[3] = '{32'h80000000,   8'hFF,  32'h80000000,   8'h00,  34};
        vecs[4] = '{32'd1000,       8'h80,  32'hFFFFFFF9,   8'h68,  34};
        vecs[5] = '{32'd1234,       8'h00,  32'hFFFFFFFF,   8'hD2,  2};
        vecs[6] = '{-32'sd7,        8'h7F,  32'h00000000,   8'hF9,  34};
        vecs[7] = '{32'h7FFFFFFF,   8'h02,  32'h3FFFFFFF,   8'h01,  34};
        vecs[8] = '{32'hFFFFFFFF,   8'h00,  32'hFFFFFFFF,   8'hFF,  2};

        reset = 1'b0;
        ce    = 1'b1;
        start = 1'b0;
        din0  = '0;
        din1  = '0;
        #12;
        chk("rst_ready", {31'b0, ready}, 32'd1);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_quot", quot, 32'd0);
        chk("rst_rem", {24'b0, rem}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
                   vecs[i].lat, -1, 1'b0);
        end

        // Divide-by-zero result with ce low while done is high.
        run_op(32'd1234, 8'd0, 32'hFFFFFFFF, 8'hD2, 2, -1, 1'b1);

        for (int n = 0; n < 6; n++) begin
            ra = $urandom;
            rb = 8'($urandom_range(1, 255));
            if (ra == 32'h80000000) ra = 32'd1;
            sa = $signed(ra);
            sd = {{24{rb[7]}}, rb};
            mq = sa / sd;
            mr = sa % sd;
            run_op(ra, rb, mq, mr[7:0], 34, -1, 1'b0);
        end

        // ce dropped for 5 cycles after 10 iterations, stray start mid-op.
        run_op(32'd100, 8'd7, 32'd14, 8'd2, 39, 11, 1'b0);

        // Reset after 20 iterations aborts the request.
        @(negedge clk);
        din0  = 32'd100;
        din1  = 8'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_ready", {31'b0, ready}, 32'd1);
        chk("abort_quot", quot, 32'd0);
        chk("abort_rem", {24'b0, rem}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        reset  = 1'b1;
        dcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("abort_no_done", dcount, 32'd0);
        run_op(32'd50, 8'd3, 32'd16, 8'd2, 34, -1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
